spmm_row_engine: RTL and testbench

//  Downstream consumer of the CSR scheduler: computes one row of H*W per node for the GAT projection.
//  Per row it takes a header (row_len, flag), then row_len nonzeros (col_idx, value).

---
 rtl/spmm_row_engine_pkg.sv | 34 +++
 rtl/spmm_row_engine_if.sv | 63 ++++++
 rtl/spmm_row_engine_mac_lane.sv | 64 ++++++
 rtl/spmm_row_engine.sv | 179 +++++++++++++++++
 tb/tb_spmm_row_engine.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spmm_row_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spmm_row_engine_pkg
//  Purpose  : Shared widths, FSM state type and helpers for the sparse
//             H*W row engine (GAT projection stage).
//  Contents : c_* default widths, state_t, idx_width()
//  Revision : 1.0  initial release
// ============================================================================
package spmm_row_engine_pkg;

    localparam int c_DATA_WIDTH    = 8;
    localparam int c_H_NUM_OF_COLS = 5;
    localparam int c_W_NUM_OF_ROWS = c_H_NUM_OF_COLS;
    localparam int c_W_NUM_OF_COLS = 3;
    localparam int c_NUM_OF_NODES  = 5;
    localparam int c_COL_IDX_WIDTH = $clog2(c_H_NUM_OF_COLS);
    // A row may hold all H_NUM_OF_COLS nonzeros, so the length needs one extra code.
    localparam int c_ROW_LEN_WIDTH = $clog2(c_H_NUM_OF_COLS + 1);
    // Sum of at most H_NUM_OF_COLS full-width products: never overflows.
    localparam int c_ACC_WIDTH     = 2 * c_DATA_WIDTH + $clog2(c_H_NUM_OF_COLS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    // Width of a counter over n values; a single-node graph still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spmm_row_engine_if.sv
`default_nettype none
// ============================================================================
//  Module   : spmm_row_engine_if
//  Purpose  : Bundles the row-header, nonzero and result handshakes plus the
//             weight matrix and status flags of spmm_row_engine.
//  Modports : master - scheduler / downstream side (drives *_i)
//             slave  - engine side (drives *_o)
//  Revision : 1.0  initial release
// ============================================================================
interface spmm_row_engine_if
    import spmm_row_engine_pkg::*;
#(
    parameter int DATA_WIDTH    = c_DATA_WIDTH,
    parameter int W_NUM_OF_ROWS = c_W_NUM_OF_ROWS,
    parameter int W_NUM_OF_COLS = c_W_NUM_OF_COLS,
    parameter int COL_IDX_WIDTH = c_COL_IDX_WIDTH,
    parameter int ROW_LEN_WIDTH = c_ROW_LEN_WIDTH,
    parameter int ACC_WIDTH     = c_ACC_WIDTH,
    parameter int ROW_IDX_WIDTH = idx_width(c_NUM_OF_NODES)
);

    // Row header
    logic                                          row_valid_i;
    logic                                          row_ready_o;
    logic [ROW_LEN_WIDTH-1:0]                      row_len_i;
    logic                                          row_flag_i;
    // Nonzero stream
    logic                                          nz_valid_i;
    logic                                          nz_ready_o;
    logic [COL_IDX_WIDTH-1:0]                      nz_col_idx_i;
    logic [DATA_WIDTH-1:0]                         nz_value_i;
    // Flattened row-major weight matrix
    logic [W_NUM_OF_ROWS*W_NUM_OF_COLS*DATA_WIDTH-1:0] weight_i;
    // Result
    logic                                          res_valid_o;
    logic                                          res_ready_i;
    logic [W_NUM_OF_COLS*ACC_WIDTH-1:0]            res_data_o;
    logic                                          res_flag_o;
    logic [ROW_IDX_WIDTH-1:0]                      res_row_idx_o;
    // Status
    logic                                          busy_o;
    logic                                          err_o;

    modport master (
        output row_valid_i, row_len_i, row_flag_i,
        output nz_valid_i, nz_col_idx_i, nz_value_i,
        output weight_i, res_ready_i,
        input  row_ready_o, nz_ready_o,
        input  res_valid_o, res_data_o, res_flag_o, res_row_idx_o,
        input  busy_o, err_o
    );

    modport slave (
        input  row_valid_i, row_len_i, row_flag_i,
        input  nz_valid_i, nz_col_idx_i, nz_value_i,
        input  weight_i, res_ready_i,
        output row_ready_o, nz_ready_o,
        output res_valid_o, res_data_o, res_flag_o, res_row_idx_o,
        output busy_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/spmm_row_engine_mac_lane.sv
`default_nettype none
// ============================================================================
//  Module   : spmm_mac_lane
//  Purpose  : One output-feature lane: selects W[col_idx][LANE], multiplies it
//             by the nonzero value and accumulates into a clearable register.
//  Ports    : clk, rst           clock, async active-high reset
//             i_clear            zero the accumulator (new row)
//             i_enable           add the current product
//             i_col_idx/i_value  current nonzero
//             i_weight           full flattened W matrix
//             o_acc              accumulated lane sum
//  Revision : 1.0  initial release
// ============================================================================
module spmm_mac_lane
    import spmm_row_engine_pkg::*;
#(
    parameter int DATA_WIDTH    = c_DATA_WIDTH,
    parameter int W_NUM_OF_ROWS = c_W_NUM_OF_ROWS,
    parameter int W_NUM_OF_COLS = c_W_NUM_OF_COLS,
    parameter int COL_IDX_WIDTH = c_COL_IDX_WIDTH,
    parameter int ACC_WIDTH     = c_ACC_WIDTH,
    parameter int LANE          = 0
) (
    input  wire logic                                              clk,
    input  wire logic                                              rst,
    input  wire logic                                              i_clear,
    input  wire logic                                              i_enable,
    input  wire logic [COL_IDX_WIDTH-1:0]                          i_col_idx,
    input  wire logic [DATA_WIDTH-1:0]                             i_value,
    input  wire logic [W_NUM_OF_ROWS*W_NUM_OF_COLS*DATA_WIDTH-1:0] i_weight,
    output logic      [ACC_WIDTH-1:0]                              o_acc
);

    logic [DATA_WIDTH-1:0] w_weight;
    logic [ACC_WIDTH-1:0]  w_product;
    logic [ACC_WIDTH-1:0]  r_acc;

    // Indices with no matching weight row select zero, so an out-of-range
    // column contributes nothing to the sum.
    always_comb begin
        w_weight = '0;
        for (int r = 0; r < W_NUM_OF_ROWS; r++) begin
            if (i_col_idx == COL_IDX_WIDTH'(r)) begin
                w_weight = i_weight[(r*W_NUM_OF_COLS+LANE)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_product = ACC_WIDTH'(i_value) * ACC_WIDTH'(w_weight);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_enable) begin
            r_acc <= r_acc + w_product;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/spmm_row_engine.sv
`default_nettype none
// ============================================================================
//  Module   : spmm_row_engine
//  Purpose  : Computes one row of H*W per node. Takes a row header, then
//             row_len nonzeros, MACs each one against W[col_idx][*] in all
//             lanes at once, and hands the finished vector downstream.
//  Ports    : clk, rst  clock, async active-high reset
//             bus       spmm_row_engine_if.slave (header, nonzero and result
//                       handshakes, weight matrix, busy/err status)
//  Revision : 1.0  initial release
// ============================================================================
module spmm_row_engine
    import spmm_row_engine_pkg::*;
#(
    parameter int DATA_WIDTH    = c_DATA_WIDTH,
    parameter int H_NUM_OF_COLS = c_H_NUM_OF_COLS,
    parameter int W_NUM_OF_ROWS = H_NUM_OF_COLS,
    parameter int W_NUM_OF_COLS = c_W_NUM_OF_COLS,
    parameter int NUM_OF_NODES  = c_NUM_OF_NODES,
    parameter int COL_IDX_WIDTH = $clog2(H_NUM_OF_COLS),
    parameter int ROW_LEN_WIDTH = $clog2(H_NUM_OF_COLS + 1),
    parameter int ACC_WIDTH     = 2 * DATA_WIDTH + $clog2(H_NUM_OF_COLS + 1)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    spmm_row_engine_if.slave  bus
);

    localparam int c_ROW_IDX_WIDTH = idx_width(NUM_OF_NODES);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [ROW_LEN_WIDTH-1:0]  r_row_len;
    logic [ROW_LEN_WIDTH-1:0]  r_cnt;
    logic                      r_flag;
    logic                      r_err;
    logic [c_ROW_IDX_WIDTH-1:0] r_row_idx;

    logic w_row_hs;
    logic w_nz_hs;
    logic w_res_hs;
    logic w_last_nz;
    logic w_bad_col;

    logic [W_NUM_OF_COLS-1:0][ACC_WIDTH-1:0] w_acc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state, handshakes and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        bus.row_ready_o = 1'b0;
        bus.nz_ready_o  = 1'b0;
        bus.res_valid_o = 1'b0;
        bus.busy_o      = 1'b1;

        unique case (r_state)
            IDLE: begin
                bus.row_ready_o = 1'b1;
                bus.busy_o      = 1'b0;
            end
            ACCUM: begin
                bus.nz_ready_o = 1'b1;
            end
            EMIT: begin
                bus.res_valid_o = 1'b1;
            end
            default: begin
                bus.busy_o = 1'b1;
            end
        endcase

        w_row_hs  = bus.row_valid_i && bus.row_ready_o;
        w_nz_hs   = bus.nz_valid_i  && bus.nz_ready_o;
        w_res_hs  = bus.res_valid_o && bus.res_ready_i;
        w_last_nz = (r_cnt == r_row_len - ROW_LEN_WIDTH'(1));
        w_bad_col = (int'(bus.nz_col_idx_i) >= W_NUM_OF_ROWS);

        unique case (r_state)
            IDLE: begin
                if (w_row_hs) begin
                    // An empty row skips accumulation and emits the cleared vector.
                    w_state_next = (bus.row_len_i == '0) ? EMIT : ACCUM;
                end
            end
            ACCUM: begin
                if (w_nz_hs && w_last_nz) begin
                    w_state_next = EMIT;
                end
            end
            EMIT: begin
                if (w_res_hs) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Row bookkeeping: length, flag, nonzero counter, row index, error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_len <= '0;
            r_flag    <= 1'b0;
            r_cnt     <= '0;
            r_row_idx <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_row_hs) begin
                r_row_len <= bus.row_len_i;
                r_flag    <= bus.row_flag_i;
                r_cnt     <= '0;
            end else if (w_nz_hs) begin
                r_cnt <= r_cnt + ROW_LEN_WIDTH'(1);
            end

            // Sticky until reset; the offending term itself adds zero.
            if (w_nz_hs && w_bad_col) begin
                r_err <= 1'b1;
            end

            if (w_res_hs) begin
                if (r_row_idx == c_ROW_IDX_WIDTH'(NUM_OF_NODES - 1)) begin
                    r_row_idx <= '0;
                end else begin
                    r_row_idx <= r_row_idx + c_ROW_IDX_WIDTH'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Parallel MAC lanes, one per output feature
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < W_NUM_OF_COLS; g++) begin : g_lane
            spmm_mac_lane #(
                .DATA_WIDTH    (DATA_WIDTH),
                .W_NUM_OF_ROWS (W_NUM_OF_ROWS),
                .W_NUM_OF_COLS (W_NUM_OF_COLS),
                .COL_IDX_WIDTH (COL_IDX_WIDTH),
                .ACC_WIDTH     (ACC_WIDTH),
                .LANE          (g)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .i_clear   (w_row_hs),
                .i_enable  (w_nz_hs),
                .i_col_idx (bus.nz_col_idx_i),
                .i_value   (bus.nz_value_i),
                .i_weight  (bus.weight_i),
                .o_acc     (w_acc[g])
            );
        end
    endgenerate

    // Accumulators are untouched in EMIT, so the result holds while stalled.
    assign bus.res_data_o    = w_acc;
    assign bus.res_flag_o    = r_flag;
    assign bus.res_row_idx_o = r_row_idx;
    assign bus.err_o         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spmm_row_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spmm_row_engine
//  Purpose  : Self-checking bench for spmm_row_engine. A golden H*W row model
//             fills an expected-result queue; one compare process checks every
//             result handshake and hold-stability while stalled.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spmm_row_engine;
    import spmm_row_engine_pkg::*;

    localparam int DW = c_DATA_WIDTH;
    localparam int NR = c_W_NUM_OF_ROWS;
    localparam int NC = c_W_NUM_OF_COLS;
    localparam int AW = c_ACC_WIDTH;
    localparam int NN = c_NUM_OF_NODES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spmm_row_engine_if bus ();

    spmm_row_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [NC-1:0][31:0] d;
        logic                flag;
        logic [31:0]         idx;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    int   model_idx = 0;
    int   model_w[NR][NC];
    int   got_l0[$];
    int   got_idx[$];

    // Graph used for the full-graph runs
    int t2_len [5]    = '{2, 2, 2, 1, 1};
    int t2_cols[5][5] = '{'{0,4,0,0,0}, '{2,4,0,0,0}, '{1,3,0,0,0}, '{2,0,0,0,0}, '{4,0,0,0,0}};
    int t2_vals[5][5] = '{'{2,9,0,0,0}, '{7,8,0,0,0}, '{6,5,0,0,0}, '{3,0,0,0,0}, '{1,0,0,0,0}};
    int lit    [5]    = '{47, 61, 32, 9, 5};
    int zero5  [5]    = '{0, 0, 0, 0, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Golden row: plain sum of value * W[col][c]; columns past the matrix add nothing.
    function automatic void model_row(input int len, input int cols[5], input int vals[5],
                                      output int res[NC]);
        for (int c = 0; c < NC; c++) res[c] = 0;
        for (int i = 0; i < len; i++)
            if (cols[i] < NR)
                for (int c = 0; c < NC; c++) res[c] += vals[i] * model_w[cols[i]][c];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_row_hs();
        bit ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (bus.row_ready_o) ok = 1'b1;
            step();
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL row_hs_timeout: got no row_ready_o within 200 cycles");
        end
    endtask

    task automatic wait_nz_hs();
        bit ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (bus.nz_ready_o) ok = 1'b1;
            step();
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL nz_hs_timeout: got no nz_ready_o within 200 cycles");
        end
    endtask

    task automatic send_row(input int len, input bit flag, input int cols[5],
                            input int vals[5], input int gap_max);
        int   res[NC];
        exp_t e;
        repeat ($urandom_range(0, gap_max)) step();
        bus.row_valid_i = 1'b1;
        bus.row_len_i   = 3'(len);
        bus.row_flag_i  = flag;
        wait_row_hs();
        bus.row_valid_i = 1'b0;
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, gap_max)) step();
            bus.nz_valid_i   = 1'b1;
            bus.nz_col_idx_i = 3'(cols[i]);
            bus.nz_value_i   = DW'(vals[i]);
            wait_nz_hs();
            bus.nz_valid_i = 1'b0;
        end
        model_row(len, cols, vals, res);
        for (int c = 0; c < NC; c++) e.d[c] = res[c];
        e.flag = flag;
        e.idx  = model_idx;
        exp_q.push_back(e);
        model_idx = (model_idx + 1) % NN;
        @(negedge clk);
        check("latency_res_valid", bus.res_valid_o, 1);
        step();
    endtask

    task automatic drain_random();
        bit ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            bus.res_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.res_valid_o && bus.res_ready_i) ok = 1'b1;
            step();
        end
        bus.res_ready_i = 1'b1;
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL result_timeout: got no result handshake within 200 cycles");
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        repeat (2) step();
        exp_q.delete();
        model_idx = 0;
        rst = 1'b0;
        step();
    endtask

    // ------------------------------------------------------------------
    // Compare process: result contents at each handshake, stability while stalled
    // ------------------------------------------------------------------
    logic                 prev_stall = 1'b0;
    logic [NC*AW-1:0]     prev_data;
    logic                 prev_flag;
    logic [31:0]          prev_idx;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else if (bus.res_valid_o) begin
            if (prev_stall) begin
                check("hold_data", 64'(bus.res_data_o), 64'(prev_data));
                check("hold_flag", bus.res_flag_o, prev_flag);
                check("hold_idx", bus.res_row_idx_o, prev_idx);
            end
            if (bus.res_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_result: got row_idx %0d with no row pending",
                             bus.res_row_idx_o);
                end else begin
                    e = exp_q.pop_front();
                    for (int c = 0; c < NC; c++)
                        check($sformatf("res_lane%0d", c), bus.res_data_o[c*AW +: AW], e.d[c]);
                    check("res_flag", bus.res_flag_o, e.flag);
                    check("res_row_idx", bus.res_row_idx_o, e.idx);
                    got_l0.push_back(int'(bus.res_data_o[AW-1:0]));
                    got_idx.push_back(int'(bus.res_row_idx_o));
                end
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                prev_data  = bus.res_data_o;
                prev_flag  = bus.res_flag_o;
                prev_idx   = 32'(bus.res_row_idx_o);
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int res[NC];

        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                model_w[r][c] = r + 1;
                bus.weight_i[(r*NC+c)*DW +: DW] = DW'(r + 1);
            end
        bus.row_valid_i  = 1'b0;
        bus.row_len_i    = '0;
        bus.row_flag_i   = 1'b0;
        bus.nz_valid_i   = 1'b0;
        bus.nz_col_idx_i = '0;
        bus.nz_value_i   = '0;
        bus.res_ready_i  = 1'b1;

        // Pin the golden model against hand-computed sums
        for (int i = 0; i < 5; i++) begin
            model_row(t2_len[i], t2_cols[i], t2_vals[i], res);
            check($sformatf("model_row%0d", i), res[0], lit[i]);
        end
        model_row(2, '{7,1,0,0,0}, '{5,2,0,0,0}, res);
        check("model_badcol", res[2], 4);

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_row_ready", bus.row_ready_o, 1);
        check("rst_nz_ready", bus.nz_ready_o, 0);
        check("rst_res_valid", bus.res_valid_o, 0);
        check("rst_res_data", 64'(bus.res_data_o), 0);
        check("rst_res_flag", bus.res_flag_o, 0);
        check("rst_row_idx", bus.res_row_idx_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_err", bus.err_o, 0);
        step();

        // Single row of length 2 -> {47,47,47}, idx 0
        send_row(2, 1'b1, t2_cols[0], t2_vals[0], 0);
        repeat (2) step();

        // Full graph from a fresh reset: idx 0..4
        reset_pulse();
        got_l0.delete();
        got_idx.delete();
        for (int i = 0; i < 5; i++) send_row(t2_len[i], 1'(i % 2), t2_cols[i], t2_vals[i], 0);
        repeat (3) step();
        check("graph_count", got_l0.size(), 5);
        for (int i = 0; i < 5 && i < got_l0.size(); i++) begin
            check($sformatf("graph_lit%0d", i), got_l0[i], lit[i]);
            check($sformatf("graph_idx%0d", i), got_idx[i], i);
        end
        check("graph_err_clear", bus.err_o, 0);

        // Downstream stall for 10 cycles; index has wrapped to 0
        bus.res_ready_i = 1'b0;
        send_row(1, 1'b0, '{2,0,0,0,0}, '{3,0,0,0,0}, 0);
        repeat (10) begin
            @(negedge clk);
            check("stall_row_ready", bus.row_ready_o, 0);
            check("stall_res_valid", bus.res_valid_o, 1);
        end
        step();
        bus.res_ready_i = 1'b1;
        repeat (2) step();
        check("wrap_idx", got_idx[got_idx.size()-1], 0);

        // Empty row while a nonzero is offered: it must stay stalled
        bus.nz_valid_i   = 1'b1;
        bus.nz_col_idx_i = 3'd0;
        bus.nz_value_i   = 8'd1;
        send_row(0, 1'b1, zero5, zero5, 0);
        repeat (3) begin
            @(negedge clk);
            check("empty_nz_stalled", bus.nz_ready_o, 0);
        end
        step();
        bus.nz_valid_i = 1'b0;

        // Out-of-range column -> {4,4,4}, sticky error
        send_row(2, 1'b0, '{7,1,0,0,0}, '{5,2,0,0,0}, 0);
        step();
        check("err_set", bus.err_o, 1);
        send_row(1, 1'b1, '{0,0,0,0,0}, '{3,0,0,0,0}, 0);
        step();
        check("err_sticky", bus.err_o, 1);

        // Reset in the middle of a row: aborted, nothing emitted
        bus.row_valid_i = 1'b1;
        bus.row_len_i   = 3'd2;
        bus.row_flag_i  = 1'b1;
        wait_row_hs();
        bus.row_valid_i  = 1'b0;
        bus.nz_valid_i   = 1'b1;
        bus.nz_col_idx_i = 3'd3;
        bus.nz_value_i   = 8'd1;
        wait_nz_hs();
        bus.nz_valid_i = 1'b0;
        reset_pulse();
        @(negedge clk);
        check("abort_res_valid", bus.res_valid_o, 0);
        check("abort_busy", bus.busy_o, 0);
        check("abort_err", bus.err_o, 0);
        check("abort_row_idx", bus.res_row_idx_o, 0);
        step();
        send_row(1, 1'b0, '{3,0,0,0,0}, '{1,0,0,0,0}, 0);
        repeat (2) step();
        check("after_abort_lane0", got_l0[got_l0.size()-1], 4);
        check("after_abort_idx", got_idx[got_idx.size()-1], 0);

        // Random valid gaps and random downstream ready
        reset_pulse();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 5; i++) begin
                bus.res_ready_i = 1'b0;
                send_row(t2_len[i], 1'(($urandom_range(0, 1))), t2_cols[i], t2_vals[i], 3);
                drain_random();
            end

        repeat (5) step();
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
